// File: rtl/prbs_chk_ctrl_pkg.sv
// prbs_chk_ctrl_pkg
//   Shared types and constants for the PRBS checker controller:
//   - state_e : checker FSM states
//   - CNT_W   : width of the word and bit-error counters
//   - sat_add : saturating counter addition
package prbs_chk_ctrl_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Add b to a, clamping at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/prbs_chk_ctrl_if.sv
// prbs_chk_ctrl_if
//   Received-word stream into the PRBS checker.
//   rx_valid : rx_data carries a word this cycle
//   rx_data  : received word, SIZE bits
//   master   : stream source, slave : checker
interface prbs_chk_ctrl_if #(
  parameter int SIZE = 8
);

  logic            rx_valid;
  logic [SIZE-1:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input  rx_valid, input  rx_data);

endinterface

// File: rtl/prbs_chk_ctrl_prbs_gen.sv
// prbs_gen
//   Word-parallel Fibonacci LFSR pattern generator.
//   Each clock the LFSR advances SIZE steps; the bit shifted out of the MSB
//   at step i lands in prbs_out[i]. Seed is all ones, so with the default
//   x^7+x^6+1 taps the first word is 8'h7F.
//   Ports:
//     clk      : clock
//     reset    : synchronous active-high; while high, prbs_out holds word 0
//                and it stays there for the first cycle after release
//     prbs_out : current pattern word (registered)
module prbs_gen #(
  parameter int                SIZE     = 8,
  parameter int                LENGTH   = 7,
  parameter logic [LENGTH-1:0] PRIMPOLY = 7'b1100000
) (
  input  logic            clk,
  input  logic            reset,
  output logic [SIZE-1:0] prbs_out
);

  localparam logic [LENGTH-1:0] SEED = {LENGTH{1'b1}};

  logic [LENGTH-1:0] lfsr_r;
  logic [SIZE-1:0]   word_r;

  // LFSR state after SIZE serial steps.
  function automatic logic [LENGTH-1:0] advance(input logic [LENGTH-1:0] s);
    logic [LENGTH-1:0] t;
    t = s;
    for (int i = 0; i < SIZE; i++) begin
      t = {t[LENGTH-2:0], ^(t & PRIMPOLY)};
    end
    return t;
  endfunction

  // Word produced while stepping SIZE times from state s (first bit in LSB).
  function automatic logic [SIZE-1:0] word_of(input logic [LENGTH-1:0] s);
    logic [LENGTH-1:0] t;
    logic [SIZE-1:0]   w;
    t = s;
    w = '0;
    for (int i = 0; i < SIZE; i++) begin
      w[i] = t[LENGTH-1];
      t    = {t[LENGTH-2:0], ^(t & PRIMPOLY)};
    end
    return w;
  endfunction

  // Reset parks the output on word 0 with the state one word ahead, so the
  // first cycle after release still shows word 0 and word 1 follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= advance(SEED);
      word_r <= word_of(SEED);
    end else begin
      lfsr_r <= advance(lfsr_r);
      word_r <= word_of(lfsr_r);
    end
  end

  assign prbs_out = word_r;

endmodule

// File: rtl/prbs_chk_ctrl.sv
// prbs_chk_ctrl
//   PRBS checker controller. Waits for SYNC_WORD on the receive stream,
//   then compares every following word against a locally generated
//   reference, counting words and bit errors (saturating).
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     start      : pulse, begins a test from IDLE/DONE (cfg_len sampled)
//     abort      : return to IDLE, counters held
//     cfg_len    : words to check, 0 = until abort
//     rx         : received stream (rx_valid, rx_data)
//     busy       : in SYNC or CHECK
//     locked     : in CHECK
//     done       : in DONE
//     sync_lost  : one-cycle pulse on each CHECK -> SYNC exit
//     word_cnt   : words compared since start
//     err_cnt    : bit errors since start
module prbs_chk_ctrl
  import prbs_chk_ctrl_pkg::*;
#(
  parameter int                SIZE       = 8,
  parameter int                LENGTH     = 7,
  parameter logic [LENGTH-1:0] PRIMPOLY   = 7'b1100000,
  parameter logic [SIZE-1:0]   SYNC_WORD  = 8'h7F,
  parameter int                ERR_THRESH = 2,
  parameter int                LOSS_CNT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_len,
  prbs_chk_ctrl_if.slave    rx,
  output logic              busy,
  output logic              locked,
  output logic              done,
  output logic              sync_lost,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int               PC_W     = $clog2(SIZE + 1);
  localparam int               BAD_W    = $clog2(LOSS_CNT + 1);
  localparam logic [CNT_W-1:0] ERR_LIM  = CNT_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] LOSS_LIM = CNT_W'(LOSS_CNT);

  state_e             state_r;
  logic [CNT_W-1:0]   word_cnt_r;
  logic [CNT_W-1:0]   err_cnt_r;
  logic [CNT_W-1:0]   len_r;
  logic [BAD_W-1:0]   bad_cnt_r;
  logic               busy_r;
  logic               locked_r;
  logic               done_r;
  logic               sync_lost_r;

  logic [SIZE-1:0]    ref_word_s;
  logic [CNT_W-1:0]   rx_err_s;
  logic [CNT_W-1:0]   word_nxt_s;
  logic [CNT_W-1:0]   err_nxt_s;
  logic               sync_hit_s;
  logic               beat_s;
  logic               bad_s;
  logic               last_s;
  logic               lose_s;
  logic               stay_check_s;
  logic               gen_rst_s;

  function automatic logic [PC_W-1:0] popcount(input logic [SIZE-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < SIZE; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  // The reference generator only runs while the next cycle is still a
  // CHECK beat. Releasing it in the same cycle as the sync beat (beat 0)
  // puts word n on ref_word_s exactly when beat n arrives; every exit from
  // CHECK re-parks it on word 0 for the next sync.
  prbs_gen #(
    .SIZE     (SIZE),
    .LENGTH   (LENGTH),
    .PRIMPOLY (PRIMPOLY)
  ) u_ref_gen (
    .clk      (clk),
    .reset    (gen_rst_s),
    .prbs_out (ref_word_s)
  );

  // Per-beat comparison, counter next values and FSM decision terms.
  always_comb begin
    rx_err_s     = CNT_W'(popcount(rx.rx_data ^ ref_word_s));
    bad_s        = (rx_err_s > ERR_LIM);
    sync_hit_s   = (state_r == ST_SYNC) && rx.rx_valid && (rx.rx_data == SYNC_WORD);
    beat_s       = sync_hit_s || ((state_r == ST_CHECK) && rx.rx_valid);
    word_nxt_s   = sat_add(word_cnt_r, 32'd1);
    err_nxt_s    = sat_add(err_cnt_r, rx_err_s);
    last_s       = (len_r != 32'd0) && (word_nxt_s == len_r);
    lose_s       = bad_s && ((CNT_W'(bad_cnt_r) + 32'd1) >= LOSS_LIM);
    stay_check_s = beat_s && !abort && !last_s && !lose_s;
    gen_rst_s    = reset || !stay_check_s;
  end

  // Checker FSM with registered status outputs and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      word_cnt_r  <= 32'd0;
      err_cnt_r   <= 32'd0;
      len_r       <= 32'd0;
      bad_cnt_r   <= '0;
      busy_r      <= 1'b0;
      locked_r    <= 1'b0;
      done_r      <= 1'b0;
      sync_lost_r <= 1'b0;
    end else if (abort) begin
      state_r     <= ST_IDLE;
      bad_cnt_r   <= '0;
      busy_r      <= 1'b0;
      locked_r    <= 1'b0;
      done_r      <= 1'b0;
      sync_lost_r <= 1'b0;
    end else begin
      sync_lost_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r    <= ST_SYNC;
            word_cnt_r <= 32'd0;
            err_cnt_r  <= 32'd0;
            len_r      <= cfg_len;
            bad_cnt_r  <= '0;
            busy_r     <= 1'b1;
            locked_r   <= 1'b0;
            done_r     <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SYNC, ST_CHECK: begin
          if (beat_s) begin
            word_cnt_r <= word_nxt_s;
            err_cnt_r  <= err_nxt_s;
            // Reaching the configured length wins over loss of lock.
            if (last_s) begin
              state_r   <= ST_DONE;
              bad_cnt_r <= '0;
              busy_r    <= 1'b0;
              locked_r  <= 1'b0;
              done_r    <= 1'b1;
            end else if (lose_s) begin
              state_r     <= ST_SYNC;
              bad_cnt_r   <= '0;
              locked_r    <= 1'b0;
              sync_lost_r <= 1'b1;
            end else begin
              state_r   <= ST_CHECK;
              bad_cnt_r <= bad_s ? (bad_cnt_r + BAD_W'(1)) : '0;
              locked_r  <= 1'b1;
            end
          end else if (state_r == ST_CHECK) begin
            // Stream break: no valid word while locked.
            state_r     <= ST_SYNC;
            bad_cnt_r   <= '0;
            locked_r    <= 1'b0;
            sync_lost_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          locked_r <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign locked    = locked_r;
  assign done      = done_r;
  assign sync_lost = sync_lost_r;
  assign word_cnt  = word_cnt_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_prbs_chk_ctrl.sv
// tb_prbs_chk_ctrl
//   Self-checking bench for prbs_chk_ctrl. A second prbs_gen is the stream
//   source; beats are optionally XOR-corrupted. Expected counters are pushed
//   to a scoreboard queue as each beat is driven and popped after the edge.
module tb_prbs_chk_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] cfg_len;
  logic        busy;
  logic        locked;
  logic        done;
  logic        sync_lost;
  logic [31:0] word_cnt;
  logic [31:0] err_cnt;

  logic        tb_gen_rst;
  logic [7:0]  tb_gen_data;

  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_word;
  logic [31:0] exp_err;
  logic [63:0] sb_q[$];

  prbs_chk_ctrl_if #(.SIZE(8)) rx_bus ();

  prbs_chk_ctrl #(
    .SIZE       (8),
    .LENGTH     (7),
    .PRIMPOLY   (7'b1100000),
    .SYNC_WORD  (8'h7F),
    .ERR_THRESH (2),
    .LOSS_CNT   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_len   (cfg_len),
    .rx        (rx_bus),
    .busy      (busy),
    .locked    (locked),
    .done      (done),
    .sync_lost (sync_lost),
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt)
  );

  prbs_gen #(
    .SIZE     (8),
    .LENGTH   (7),
    .PRIMPOLY (7'b1100000)
  ) u_src_gen (
    .clk      (clk),
    .reset    (tb_gen_rst),
    .prbs_out (tb_gen_data)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Run-time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: edge, then sample on the falling edge and pop the scoreboard.
  task automatic step(input bit exp_sl);
    logic [63:0] e;
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("word_cnt", {32'd0, word_cnt}, {32'd0, e[63:32]});
      check_val("err_cnt", {32'd0, err_cnt}, {32'd0, e[31:0]});
    end
    check_val("sync_lost", {63'd0, sync_lost}, {63'd0, exp_sl});
  endtask

  // Drive one valid beat from the source generator, XORed with mask.
  task automatic send(input logic [7:0] mask, input bit counted, input bit exp_sl);
    logic [32:0] t;
    rx_bus.rx_valid = 1'b1;
    rx_bus.rx_data  = tb_gen_data ^ mask;
    tb_gen_rst      = 1'b0;
    if (counted) begin
      exp_word = exp_word + 32'd1;
      t        = {1'b0, exp_err} + 33'($countones(mask));
      exp_err  = t[32] ? 32'hFFFF_FFFF : t[31:0];
    end
    sb_q.push_back({exp_word, exp_err});
    step(exp_sl);
  endtask

  // Drive an empty cycle; the source restarts at word 0 afterwards.
  task automatic idle_cycle(input bit exp_sl);
    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_data  = 8'h00;
    tb_gen_rst      = 1'b1;
    sb_q.push_back({exp_word, exp_err});
    step(exp_sl);
  endtask

  task automatic start_test(input logic [31:0] len, input logic [31:0] later_len);
    cfg_len  = len;
    start    = 1'b1;
    exp_word = 32'd0;
    exp_err  = 32'd0;
    idle_cycle(1'b0);
    start    = 1'b0;
    cfg_len  = later_len;
    check_val("busy_sync", {63'd0, busy}, 64'd1);
    check_val("locked_sync", {63'd0, locked}, 64'd0);
  endtask

  // Main stimulus sequence.
  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    exp_word        = 32'd0;
    exp_err         = 32'd0;
    reset           = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    cfg_len         = 32'd0;
    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_data  = 8'h00;
    tb_gen_rst      = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_locked", {63'd0, locked}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_sync_lost", {63'd0, sync_lost}, 64'd0);
    check_val("rst_word_cnt", {32'd0, word_cnt}, 64'd0);
    check_val("rst_err_cnt", {32'd0, err_cnt}, 64'd0);
    check_val("gen_word0", {56'd0, tb_gen_data}, 64'h7F);
    reset = 1'b0;

    // Clean run of 100 words; cfg_len changed after start must not matter.
    start_test(32'd100, 32'd5);
    for (int i = 0; i < 100; i++) begin
      send(8'h00, 1'b1, 1'b0);
      if (i == 0) check_val("clean_locked", {63'd0, locked}, 64'd1);
    end
    check_val("clean_done", {63'd0, done}, 64'd1);
    check_val("clean_busy", {63'd0, busy}, 64'd0);
    send(8'h00, 1'b0, 1'b0);
    check_val("done_hold", {63'd0, done}, 64'd1);

    // Single-bit errors on beats 10 and 20.
    start_test(32'd50, 32'd7);
    for (int i = 0; i < 50; i++) begin
      send((i == 10 || i == 20) ? 8'h08 : 8'h00, 1'b1, 1'b0);
    end
    check_val("sbe_done", {63'd0, done}, 64'd1);

    // Loss of lock after 4 fully corrupted beats, then relock.
    start_test(32'd0, 32'd3);
    for (int i = 0; i < 10; i++) send(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hFF, 1'b1, (i == 3));
    check_val("lol_locked", {63'd0, locked}, 64'd0);
    check_val("lol_busy", {63'd0, busy}, 64'd1);
    idle_cycle(1'b0);
    for (int i = 0; i < 5; i++) send(8'h00, 1'b1, 1'b0);
    check_val("relock", {63'd0, locked}, 64'd1);

    // Stream break.
    idle_cycle(1'b1);
    check_val("brk_locked", {63'd0, locked}, 64'd0);
    idle_cycle(1'b0);
    for (int i = 0; i < 3; i++) send(8'h00, 1'b1, 1'b0);

    // Start while locked is ignored.
    start = 1'b1;
    send(8'h00, 1'b1, 1'b0);
    start = 1'b0;
    check_val("start_ign_locked", {63'd0, locked}, 64'd1);

    // Abort mid-CHECK, with a beat present that must not count.
    abort = 1'b1;
    send(8'h00, 1'b0, 1'b0);
    abort = 1'b0;
    check_val("abort_busy", {63'd0, busy}, 64'd0);
    check_val("abort_locked", {63'd0, locked}, 64'd0);
    check_val("abort_done", {63'd0, done}, 64'd0);

    // Reset mid-CHECK.
    start_test(32'd0, 32'd0);
    for (int i = 0; i < 3; i++) send(8'h00, 1'b1, 1'b0);
    reset    = 1'b1;
    exp_word = 32'd0;
    exp_err  = 32'd0;
    send(8'h00, 1'b0, 1'b0);
    reset    = 1'b0;
    check_val("rst_mid_busy", {63'd0, busy}, 64'd0);
    check_val("rst_mid_locked", {63'd0, locked}, 64'd0);
    check_val("rst_mid_done", {63'd0, done}, 64'd0);

    // Last beat also the 4th bad beat: DONE, no sync_lost.
    start_test(32'd8, 32'd8);
    for (int i = 0; i < 4; i++) send(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hFF, 1'b1, 1'b0);
    check_val("prio_done", {63'd0, done}, 64'd1);
    check_val("prio_locked", {63'd0, locked}, 64'd0);

    // Error counter saturation.
    start_test(32'd0, 32'd0);
    for (int i = 0; i < 3; i++) send(8'h00, 1'b1, 1'b0);
    force dut.err_cnt_r = 32'hFFFF_FFFD;
    #1;
    release dut.err_cnt_r;
    exp_err = 32'hFFFF_FFFD;
    check_val("err_preload", {32'd0, err_cnt}, 64'hFFFF_FFFD);
    send(8'hFF, 1'b1, 1'b0);
    check_val("err_sat", {32'd0, err_cnt}, 64'hFFFF_FFFF);
    send(8'hFF, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
